// File: rtl/i2s_pkg.sv
// Shared I2S link definitions: default sample width, channel encoding of ws,
// and the receiver framing states.
package i2s_pkg;
    localparam int   I2S_DATA_W = 16;
    localparam logic WS_LEFT    = 1'b0;
    localparam logic WS_RIGHT   = 1'b1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;
endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus a one-cycle pulse
// on each rising transition of the synchronized value.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples sck/ws/sd in the clk domain and rebuilds
// MSB-first, one-bit-delayed channel words into parallel stereo pairs.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W      = I2S_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_SLOT    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ws,
    input  logic              sd,
    output logic [DATA_W-1:0] left,
    output logic [DATA_W-1:0] right,
    output logic              valid,
    output logic              frame_err
);
    localparam int                CNT_W    = $clog2(MAX_SLOT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_SLOT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_SLOT - 1);

    logic              w_sck_rise;
    logic              w_ws;
    logic              w_sd;
    logic              w_unused_sck_sync;
    logic              w_unused_ws_rise;
    logic              w_unused_sd_rise;
    logic              w_ws_edge;
    logic              w_short;
    logic [DATA_W-1:0] w_shift_next;

    rx_state_t         r_state;
    logic              r_ws_prev;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_left_buf;
    logic [DATA_W-1:0] r_left;
    logic [DATA_W-1:0] r_right;
    logic              r_valid;
    logic              r_frame_err;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .i_async(sck), .o_sync(w_unused_sck_sync), .o_rise(w_sck_rise)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
        .clk(clk), .rst(rst), .i_async(ws), .o_sync(w_ws), .o_rise(w_unused_ws_rise)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
        .clk(clk), .rst(rst), .i_async(sd), .o_sync(w_sd), .o_rise(w_unused_sd_rise)
    );

    assign w_ws_edge = w_ws ^ r_ws_prev;
    // bit_cnt counts non-edge rises; the edge rise adds one more captured bit.
    assign w_short   = (int'(r_bit_cnt) < DATA_W - 1);

    always_comb begin
        w_shift_next = r_shift;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(r_bit_cnt) == DATA_W - 1 - i) begin
                w_shift_next[i] = w_sd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_ws_prev   <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_buf  <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_sck_rise) begin
                r_ws_prev <= w_ws;
                if (w_ws_edge) begin
                    r_shift   <= '0;
                    r_bit_cnt <= '0;
                    case (r_state)
                        HUNT: begin
                            if (w_ws == WS_LEFT) r_state <= LEFT;
                        end
                        LEFT: begin
                            if (w_ws == WS_RIGHT) begin
                                r_left_buf  <= w_shift_next;
                                r_frame_err <= w_short;
                                r_state     <= RIGHT;
                            end
                        end
                        RIGHT: begin
                            if (w_ws == WS_LEFT) begin
                                r_left      <= r_left_buf;
                                r_right     <= w_shift_next;
                                r_valid     <= 1'b1;
                                r_frame_err <= w_short;
                                r_state     <= LEFT;
                            end
                        end
                        default: r_state <= HUNT;
                    endcase
                end else begin
                    r_shift <= w_shift_next;
                    if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + 1'b1;
                    // Overlong slot: report once and drop the partial pair.
                    if (r_bit_cnt == CNT_LAST && r_state != HUNT) begin
                        r_frame_err <= 1'b1;
                        r_state     <= HUNT;
                    end
                end
            end
        end
    end

    assign left      = r_left;
    assign right     = r_right;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
endmodule
